// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: scheduler state encoding and the codec boot table.
package codec_cfg_pkg;
    typedef enum logic [2:0] {
        S_BOOT, S_BWAIT, S_IDLE, S_ISSUE, S_WAIT, S_REPLY, S_FAIL
    } state_t;
    localparam int BOOT_LEN = 9;
    // reset, power, DAC unmute/HPF, DSP fmt, path, out vol, in vol, 48 kHz, activate
    localparam logic [15:0] BOOT_ROM [BOOT_LEN] = '{
        16'h1E00, 16'h0C00, 16'h0A00, 16'h0E53, 16'h0814,
        16'h0579, 16'h0117, 16'h1000, 16'h1201
    };
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr+1.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    // walk farthest-to-nearest so the closest requester after ptr overwrites last
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant = '0;
                grant[(int'(ptr) + k) % N] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/codec_cfg_sched.sv
// codec_cfg_sched: plays the codec boot table, then round-robins client register
// writes over the I2C word writer with retry on NACK or timeout.
module codec_cfg_sched
    import codec_cfg_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 20000,
    parameter int TW        = 15
) (
    input  logic             clock50,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [16*NREQ-1:0] req_word,
    output logic [NREQ-1:0]  req_ready,
    output logic [NREQ-1:0]  req_done,
    output logic [NREQ-1:0]  req_err,
    output logic             cmd_valid,
    output logic [15:0]      cmd_word,
    input  logic             cmd_ready,
    input  logic             rsp_valid,
    input  logic             rsp_nack,
    output logic             boot_done,
    output logic             boot_fail,
    output logic             busy
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    localparam int BW = $clog2(BOOT_LEN);

    state_t          state, n_state;
    logic [BW-1:0]   boot_idx, n_boot_idx;
    logic [RW-1:0]   retry, n_retry;
    logic [IW-1:0]   rr_ptr, n_rr_ptr, g, n_g, gi;
    logic [15:0]     word, n_word;
    logic [TW-1:0]   timer, n_timer;
    logic            err, n_err, n_boot_done, n_boot_fail;
    logic [NREQ-1:0] grant;
    logic            ack, miss, can_retry;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .req(req_valid), .ptr(rr_ptr), .grant(grant), .idx(gi)
    );

    assign ack       = rsp_valid & ~rsp_nack;
    // a response on the timeout edge takes precedence over the timeout
    assign miss      = rsp_valid ? rsp_nack : (timer == TW'(TIMEOUT - 1));
    assign can_retry = retry < RW'(MAX_RETRY);

    assign cmd_valid = reset_n & (state == S_BOOT || state == S_ISSUE);
    assign cmd_word  = cmd_valid ? (state == S_BOOT ? BOOT_ROM[boot_idx] : word) : '0;
    assign busy      = reset_n & (state != S_IDLE);
    assign req_ready = state == S_IDLE ? grant : '0;
    assign req_done  = state == S_REPLY ? NREQ'(1) << g : '0;
    assign req_err   = err ? req_done : '0;

    always_comb begin
        n_state     = state;
        n_boot_idx  = boot_idx;
        n_retry     = retry;
        n_rr_ptr    = rr_ptr;
        n_word      = word;
        n_g         = g;
        n_err       = err;
        n_boot_done = boot_done;
        n_boot_fail = boot_fail;
        n_timer     = (state == S_BWAIT || state == S_WAIT) && timer != '1 ? timer + 1'b1 : timer;
        case (state)
            S_BOOT: if (cmd_ready) begin
                n_state = S_BWAIT;
                n_timer = '0;
            end
            S_BWAIT: if (ack) begin
                if (boot_idx == BW'(BOOT_LEN - 1)) begin
                    n_boot_done = 1'b1;
                    n_state     = S_IDLE;
                end else begin
                    n_boot_idx = boot_idx + 1'b1;
                    n_retry    = '0;
                    n_state    = S_BOOT;
                end
            end else if (miss) begin
                n_retry     = can_retry ? retry + 1'b1 : retry;
                n_boot_fail = !can_retry;
                n_state     = can_retry ? S_BOOT : S_FAIL;
            end
            S_IDLE: if (|grant) begin
                n_word   = req_word[{gi, 4'b0} +: 16];
                n_g      = gi;
                n_rr_ptr = gi;
                n_retry  = '0;
                n_state  = S_ISSUE;
            end
            S_ISSUE: if (cmd_ready) begin
                n_state = S_WAIT;
                n_timer = '0;
            end
            S_WAIT: if (ack) begin
                n_err   = 1'b0;
                n_state = S_REPLY;
            end else if (miss) begin
                n_retry = can_retry ? retry + 1'b1 : retry;
                n_err   = !can_retry;
                n_state = can_retry ? S_ISSUE : S_REPLY;
            end
            S_REPLY: n_state = S_IDLE;
            S_FAIL:  n_state = S_FAIL;
            default: n_state = S_BOOT;
        endcase
    end

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_BOOT;
            boot_idx  <= '0;
            retry     <= '0;
            rr_ptr    <= IW'(NREQ - 1);
            word      <= '0;
            g         <= '0;
            err       <= 1'b0;
            timer     <= '0;
            boot_done <= 1'b0;
            boot_fail <= 1'b0;
        end else begin
            state     <= n_state;
            boot_idx  <= n_boot_idx;
            retry     <= n_retry;
            rr_ptr    <= n_rr_ptr;
            word      <= n_word;
            g         <= n_g;
            err       <= n_err;
            timer     <= n_timer;
            boot_done <= n_boot_done;
            boot_fail <= n_boot_fail;
        end
    end
endmodule

// File: tb/tb_codec_cfg_sched.sv
// tb_codec_cfg_sched: scoreboard bench with writer/client models and a queue-based reference.
module tb_codec_cfg_sched;
    localparam int TO = 100;

    logic        clock50 = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_word = '0;
    logic [1:0]  req_ready, req_done, req_err;
    logic        cmd_valid;
    logic [15:0] cmd_word;
    logic        cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_nack = 1'b0;
    logic        boot_done, boot_fail, busy;

    codec_cfg_sched #(.NREQ(2), .MAX_RETRY(3), .TIMEOUT(TO), .TW(15)) dut (
        .clock50(clock50), .reset_n(reset_n), .req_valid(req_valid), .req_word(req_word),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .cmd_valid(cmd_valid), .cmd_word(cmd_word), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
        .boot_done(boot_done), .boot_fail(boot_fail), .busy(busy)
    );

    always #10 clock50 = ~clock50;

    logic [15:0] rom [9] = '{16'h1E00, 16'h0C00, 16'h0A00, 16'h0E53, 16'h0814,
                             16'h0579, 16'h0117, 16'h1000, 16'h1201};
    logic [15:0] pool [5] = '{16'h0579, 16'h0117, 16'h0814, 16'h1234, 16'h0A5A};

    int tests = 0, fails = 0;
    logic [15:0] exp_cmd [$];
    logic [15:0] cq0 [$];
    logic [15:0] cq1 [$];
    int          exp_done [$];
    logic [1:0]  exp_grant [$];
    int          rsp_cnt = 0, acks = 0, last = 1, nack_n = 0;
    logic [15:0] nack_word = '0;
    logic        pend_nack = 0, silent = 0, hold_low = 0, stray = 0, drop = 0, exp_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] v, input int l);
        for (int k = 1; k <= 2; k++)
            if (v[(l + k) % 2]) return (l + k) % 2;
        return -1;
    endfunction

    // clients and I2C writer model; predicts each grant and pushes the expected traffic
    initial begin : drv
        logic s_hs;
        logic [15:0] s_word, w;
        int g, k;
        logic [1:0] en;
        forever begin
            @(negedge clock50);
            s_hs = reset_n & cmd_valid & cmd_ready;
            s_word = cmd_word;
            g = -1;
            if (reset_n && req_ready != 0) begin
                g = pick(req_valid, last);
                if (g < 0) exp_grant.push_back(2'b00);
                else begin
                    exp_grant.push_back(2'(1 << g));
                    w = (g == 1) ? (cq1.size() > 0 ? cq1[0] : 16'h0) : (cq0.size() > 0 ? cq0[0] : 16'h0);
                    k = silent ? 4 : (w == nack_word ? nack_n : 0);
                    repeat (k < 4 ? k + 1 : 4) exp_cmd.push_back(w);
                    exp_done.push_back(g * 2 + (k >= 4 ? 1 : 0));
                    last = g;
                end
            end
            @(posedge clock50);
            #1;
            if (g == 0 && cq0.size() > 0) cq0.delete(0);
            if (g == 1 && cq1.size() > 0) cq1.delete(0);
            rsp_valid = 0;
            rsp_nack = 0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    rsp_valid = 1;
                    rsp_nack = pend_nack;
                    if (!pend_nack) acks++;
                end
            end else if (stray && !s_hs && $urandom_range(0, 2) == 0) begin
                rsp_valid = 1;
                rsp_nack = 1'($urandom_range(0, 1));
            end
            if (s_hs && !silent) begin
                pend_nack = s_word == nack_word && nack_n > 0;
                if (pend_nack) nack_n--;
                rsp_cnt = $urandom_range(1, 3);
            end
            cmd_ready = !hold_low && $urandom_range(0, 3) != 0;
            en = drop ? 2'($urandom_range(0, 3)) : 2'b11;
            req_valid = {en[1] && cq1.size() > 0, en[0] && cq0.size() > 0};
            req_word = {cq1.size() > 0 ? cq1[0] : 16'h0, cq0.size() > 0 ? cq0[0] : 16'h0};
        end
    end

    initial begin : mon
        logic p_stall, p_acc, p_cv, p_rsp, p_bd, p_bf, sil_hs;
        logic [15:0] p_word;
        logic [1:0] oh;
        int cyc, hs_cyc, e;
        {p_stall, p_acc, p_cv, p_rsp, p_bd, p_bf, sil_hs} = '0;
        p_word = '0;
        cyc = 0;
        hs_cyc = 0;
        forever begin
            @(negedge clock50);
            #2;
            cyc++;
            if (!reset_n) begin
                {p_stall, p_acc, p_cv, p_rsp, p_bd, p_bf, sil_hs} = '0;
            end else begin
                if (!boot_done && req_valid != 0) chk("ready_before_boot", 32'(req_ready), 0);
                if (p_stall) chk("stall_hold", {cmd_valid, cmd_word}, {1'b1, p_word});
                if (p_acc) chk("accept_to_cmd", 32'(cmd_valid), 1);
                if (req_ready != 0) begin
                    if (exp_grant.size() == 0) chk("grant_unexpected", 32'(req_ready), 0);
                    else chk("grant", 32'(req_ready), 32'(exp_grant.pop_front()));
                end
                if (silent && sil_hs && ((cmd_valid && !p_cv) || req_done != 0)) begin
                    chk("timeout_gap", cyc - hs_cyc, TO + 1);
                    sil_hs = 0;
                end
                if (cmd_valid && cmd_ready) begin
                    if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'(cmd_word), 32'hFFFF_FFFF);
                    else chk("cmd_word", 32'(cmd_word), 32'(exp_cmd.pop_front()));
                    hs_cyc = cyc;
                    sil_hs = silent;
                end
                if (req_done != 0) begin
                    if (!silent) chk("done_latency", 32'(p_rsp), 1);
                    if (exp_done.size() == 0) chk("done_unexpected", 32'(req_done), 0);
                    else begin
                        e = exp_done.pop_front();
                        oh = 2'(1 << (e / 2));
                        chk("done", {req_done, req_err}, {oh, (e % 2 != 0) ? oh : 2'b00});
                    end
                end
                if (boot_done && !p_bd) chk("boot_done_acks", acks, 9);
                if (boot_fail && !p_bf) begin
                    chk("boot_fail_plan", 32'(exp_fail), 1);
                    chk("boot_fail_pending", exp_cmd.size(), 0);
                end
                p_stall = cmd_valid && !cmd_ready;
                p_word = cmd_word;
                p_acc = (req_valid & req_ready) != 0;
                p_cv = cmd_valid;
                p_rsp = rsp_valid;
                p_bd = boot_done;
                p_bf = boot_fail;
            end
        end
    end

    task automatic do_reset(input logic [15:0] nw, input int nn);
        int k;
        reset_n = 0;
        @(posedge clock50);
        #2;
        exp_cmd.delete(); exp_done.delete(); exp_grant.delete(); cq0.delete(); cq1.delete();
        rsp_cnt = 0; acks = 0; last = 1; silent = 0; hold_low = 0; stray = 0; drop = 0;
        nack_word = nw; nack_n = nn; exp_fail = 0;
        for (int i = 0; i < 9; i++) begin
            k = (rom[i] == nw) ? nn : 0;
            repeat (k < 4 ? k + 1 : 4) exp_cmd.push_back(rom[i]);
            if (k >= 4) begin
                exp_fail = 1;
                break;
            end
        end
        @(posedge clock50);
        #2;
        reset_n = 1;
    endtask

    task automatic wait_boot(input logic want_fail);
        int n = 0;
        while (!(want_fail ? boot_fail : boot_done) && n < 3000) begin
            @(negedge clock50);
            n++;
        end
        chk(want_fail ? "boot_fail_wait" : "boot_done_wait", 32'(want_fail ? boot_fail : boot_done), 1);
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (exp_cmd.size() + exp_done.size() + cq0.size() + cq1.size() != 0 && n < limit) begin
            @(negedge clock50);
            #3;
            n++;
        end
        @(negedge clock50);
        #3;
        chk(name, exp_cmd.size() + exp_done.size() + cq0.size() + cq1.size(), 0);
        chk({name, "_idle"}, 32'(busy), 0);
    endtask

    function automatic logic [31:0] outs();
        return 32'({cmd_valid, cmd_word, req_ready, req_done, req_err, boot_done, boot_fail, busy});
    endfunction

    initial begin : main
        int n;
        reset_n = 1;
        #1 reset_n = 0;
        #24;
        chk("reset_outputs", outs(), 0);
        do_reset(16'h0000, 0);
        repeat (4) begin
            cq0.push_back(16'h0579);
            cq1.push_back(16'h0117);
        end
        wait_boot(0);
        drain("rr_drain", 2000);
        do_reset(16'h0E53, 2);
        wait_boot(0);
        chk("boot_retry_no_fail", 32'(boot_fail), 0);
        do_reset(16'h0E53, 4);
        cq0.push_back(16'h0579);
        wait_boot(1);
        repeat (50) @(negedge clock50);
        #3;
        chk("fail_terminal", 32'({cmd_valid, boot_done, busy, req_ready}), 32'b00100);
        do_reset(16'h0000, 0);
        wait_boot(0);
        silent = 1;
        cq0.push_back(16'h0117);
        drain("timeout_drain", 1500);
        cq1.push_back(16'h0C3A);
        n = 0;
        while (!(cmd_valid && cmd_ready) && n < 200) begin
            @(negedge clock50);
            n++;
        end
        chk("reach_wait", 32'(cmd_valid && cmd_ready), 1);
        repeat (5) @(negedge clock50);
        #5 reset_n = 0;
        #1 chk("async_reset", outs(), 0);
        do_reset(16'h0000, 0);
        wait_boot(0);
        hold_low = 1;
        cq0.push_back(16'h0A5A);
        repeat (52) @(negedge clock50);
        hold_low = 0;
        drain("stall_drain", 500);
        stray = 1;
        repeat (30) begin
            @(negedge clock50);
            #3;
            chk("stray_idle", 32'({busy, cmd_valid, req_done}), 0);
        end
        stray = 0;
        drop = 1;
        nack_word = 16'h0579;
        nack_n = 6;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) cq0.push_back(pool[$urandom_range(0, 4)]);
            else cq1.push_back(pool[$urandom_range(0, 4)]);
        end
        drain("random_drain", 8000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
